// File: rtl/sram_controller_if.sv
// Request/response bundle between the MEM stage and the SRAM controller.
// Handshake: the master holds rd_en/wr_en with address/write_data; the slave pulls ready low in the
// same cycle it sees the request and raises it for one cycle when the access completes.
interface sram_controller_if;
  logic        wr_en;
  logic        rd_en;
  logic [31:0] address;
  logic [31:0] write_data;
  logic [31:0] read_data;
  logic        ready;

  modport master (
    output wr_en, rd_en, address, write_data,
    input  read_data, ready
  );

  modport slave (
    input  wr_en, rd_en, address, write_data,
    output read_data, ready
  );
endinterface

// File: rtl/sram_controller.sv
// MEM-stage responder: one 32-bit word access performed as two half-word cycles on a 16-bit
// asynchronous SRAM, followed by wait states so the whole access lasts WAIT_CYCLES cycles.
module sram_controller #(
  parameter int BASE_ADDR   = 1024,
  parameter int SRAM_ADDR_W = 18,
  parameter int WAIT_CYCLES = 5
) (
  input  logic                   clk,
  input  logic                   rst,
  sram_controller_if.slave       bus,
  inout  wire  [15:0]            SRAM_DQ,
  output logic [SRAM_ADDR_W-1:0] SRAM_ADDR,
  output logic                   SRAM_WE_N,
  output logic                   SRAM_OE_N,
  output logic                   SRAM_CE_N,
  output logic                   SRAM_UB_N,
  output logic                   SRAM_LB_N,
  output logic [2:0]             state_dbg
);

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_LO   = 3'd1,
    ST_HI   = 3'd2,
    ST_WAIT = 3'd3,
    ST_DONE = 3'd4
  } state_t;

  localparam int CNT_W = $clog2(WAIT_CYCLES + 1);

  state_t                   state, state_next;
  logic [CNT_W-1:0]         wait_cnt;
  logic [SRAM_ADDR_W-2:0]   word_q;
  logic [31:0]              wdata_q;
  logic                     write_q;
  logic [SRAM_ADDR_W-1:0]   sram_addr_q;
  logic [15:0]              rdata_lo;
  logic [15:0]              rdata_hi;
  logic [31:0]              read_data_q;
  logic [31:0]              offset;
  logic                     req;
  logic                     drive;
  logic [15:0]              dq_out;
  logic                     unused_offset_bits;

  assign req    = bus.rd_en | bus.wr_en;
  assign offset = bus.address - 32'(BASE_ADDR);
  // Word index wraps silently; byte-lane bits and high bits beyond the SRAM are dropped.
  assign unused_offset_bits = ^{offset[31:SRAM_ADDR_W+1], offset[1:0]};

  always_comb begin
    state_next = state;
    case (state)
      ST_IDLE: if (req) state_next = ST_LO;
      ST_LO:   state_next = ST_HI;
      ST_HI:   state_next = (WAIT_CYCLES > 3) ? ST_WAIT : ST_DONE;
      ST_WAIT: if (wait_cnt <= CNT_W'(1)) state_next = ST_DONE;
      ST_DONE: state_next = ST_IDLE;
      default: state_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= ST_IDLE;
      wait_cnt    <= '0;
      word_q      <= '0;
      wdata_q     <= '0;
      write_q     <= 1'b0;
      sram_addr_q <= '0;
      rdata_lo    <= '0;
      rdata_hi    <= '0;
      read_data_q <= '0;
    end else begin
      state <= state_next;
      case (state)
        ST_IDLE: begin
          if (req) begin
            word_q      <= offset[SRAM_ADDR_W:2];
            wdata_q     <= bus.write_data;
            write_q     <= bus.wr_en;
            sram_addr_q <= {offset[SRAM_ADDR_W:2], 1'b0};
          end
        end
        ST_LO: begin
          if (!write_q) rdata_lo <= SRAM_DQ;
          sram_addr_q <= {word_q, 1'b1};
        end
        ST_HI: begin
          if (!write_q) rdata_hi <= SRAM_DQ;
          wait_cnt <= CNT_W'(WAIT_CYCLES - 3);
          // With no wait states the high half goes straight into read_data.
          if (!write_q && state_next == ST_DONE) read_data_q <= {SRAM_DQ, rdata_lo};
        end
        ST_WAIT: begin
          wait_cnt <= wait_cnt - 1'b1;
          if (!write_q && state_next == ST_DONE) read_data_q <= {rdata_hi, rdata_lo};
        end
        default: ;
      endcase
    end
  end

  assign drive     = write_q && (state == ST_LO || state == ST_HI);
  assign dq_out    = (state == ST_HI) ? wdata_q[31:16] : wdata_q[15:0];
  assign SRAM_DQ   = drive ? dq_out : 16'hzzzz;
  assign SRAM_WE_N = ~drive;
  assign SRAM_ADDR = sram_addr_q;
  assign SRAM_OE_N = 1'b0;
  assign SRAM_CE_N = 1'b0;
  assign SRAM_UB_N = 1'b0;
  assign SRAM_LB_N = 1'b0;
  assign state_dbg = state;

  assign bus.ready     = (state == ST_IDLE && !req) || (state == ST_DONE);
  assign bus.read_data = read_data_q;

endmodule

// File: tb/tb_sram_controller.sv
// Directed bench: a 5-wait-state and a 3-wait-state controller, each on its own SRAM model.
module tb_sram_controller;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  sram_controller_if bus5();
  sram_controller_if bus3();

  wire  [15:0] dq5, dq3;
  logic [17:0] addr5, addr3;
  logic        we5_n, we3_n;
  logic        oe5_n, ce5_n, ub5_n, lb5_n;
  logic        oe3_n, ce3_n, ub3_n, lb3_n;
  logic [2:0]  st5, st3;

  sram_controller dut5 (
    .clk(clk), .rst(rst), .bus(bus5.slave),
    .SRAM_DQ(dq5), .SRAM_ADDR(addr5), .SRAM_WE_N(we5_n),
    .SRAM_OE_N(oe5_n), .SRAM_CE_N(ce5_n), .SRAM_UB_N(ub5_n), .SRAM_LB_N(lb5_n),
    .state_dbg(st5)
  );

  sram_controller #(.WAIT_CYCLES(3)) dut3 (
    .clk(clk), .rst(rst), .bus(bus3.slave),
    .SRAM_DQ(dq3), .SRAM_ADDR(addr3), .SRAM_WE_N(we3_n),
    .SRAM_OE_N(oe3_n), .SRAM_CE_N(ce3_n), .SRAM_UB_N(ub3_n), .SRAM_LB_N(lb3_n),
    .state_dbg(st3)
  );

  // SRAM models: written on the clock edge while WE_N is low, otherwise they drive the bus.
  logic [15:0] mem5 [256];
  logic [15:0] mem3 [256];

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < 256; i++) mem5[i] <= 16'hC3C3;
    end else if (!we5_n) begin
      mem5[addr5[7:0]] <= dq5;
    end
  end

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < 256; i++) mem3[i] <= 16'hC3C3;
    end else if (!we3_n) begin
      mem3[addr3[7:0]] <= dq3;
    end
  end

  assign dq5 = we5_n ? mem5[addr5[7:0]] : 16'hzzzz;
  assign dq3 = we3_n ? mem3[addr3[7:0]] : 16'hzzzz;

  logic saw_wait3;
  always @(negedge clk or posedge rst) begin
    if (rst) saw_wait3 <= 1'b0;
    else if (st3 == 3'd3) saw_wait3 <= 1'b1;
  end

  logic        sel;
  logic        cur_ready, cur_we_n;
  logic [17:0] cur_addr;
  logic [31:0] cur_rdata;
  assign cur_ready = sel ? bus3.ready     : bus5.ready;
  assign cur_we_n  = sel ? we3_n          : we5_n;
  assign cur_addr  = sel ? addr3          : addr5;
  assign cur_rdata = sel ? bus3.read_data : bus5.read_data;

  int checks = 0;
  int errors = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic set_req(input logic w, input logic r, input logic [31:0] a, input logic [31:0] d);
    if (sel) begin
      bus3.wr_en = w; bus3.rd_en = r; bus3.address = a; bus3.write_data = d;
    end else begin
      bus5.wr_en = w; bus5.rd_en = r; bus5.address = a; bus5.write_data = d;
    end
  endtask

  // Called after a request is applied; returns at the negedge of the DONE cycle.
  task automatic wait_done(output int low_cnt, output int we_cnt,
                           output logic [17:0] a1, output logic [17:0] a2);
    low_cnt = 0; we_cnt = 0; a1 = '0; a2 = '0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (cur_ready) break;
      if (low_cnt == 1) a1 = cur_addr;
      if (low_cnt == 2) a2 = cur_addr;
      low_cnt++;
      if (!cur_we_n) we_cnt++;
    end
    check("done_timeout", {31'd0, cur_ready}, 32'd1);
  endtask

  int          lc, wc, idle_low;
  logic [17:0] a1, a2;

  initial begin
    rst = 1'b1;
    sel = 1'b0;
    bus5.wr_en = 0; bus5.rd_en = 0; bus5.address = 0; bus5.write_data = 0;
    bus3.wr_en = 0; bus3.rd_en = 0; bus3.address = 0; bus3.write_data = 0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;

    // Reset in the middle of the low-half write cycle
    @(posedge clk); #1 set_req(1, 0, 32'd1024, 32'h77778888);
    @(negedge clk);
    check("t1_req_ready", {31'd0, bus5.ready}, 32'd0);
    @(negedge clk);
    check("t1_lo_we_n", {31'd0, we5_n}, 32'd0);
    rst = 1'b1;
    #1;
    check("t1_rst_we_n", {31'd0, we5_n}, 32'd1);
    check("t1_rst_dq", {16'd0, dq5}, 32'h0000C3C3);
    check("t1_rst_addr", {14'd0, addr5}, 32'd0);
    set_req(0, 0, 32'd0, 32'd0);
    @(posedge clk); #1 rst = 1'b0;
    @(negedge clk);
    check("t1_ready", {31'd0, bus5.ready}, 32'd1);
    check("t1_rdata", bus5.read_data, 32'd0);
    check("t1_state", {29'd0, st5}, 32'd0);

    // Write 1024 <- DEADBEEF
    @(posedge clk); #1 set_req(1, 0, 32'd1024, 32'hDEADBEEF);
    wait_done(lc, wc, a1, a2);
    set_req(0, 0, 32'd0, 32'd0);
    check("t2_low", lc, 32'd5);
    check("t2_we", wc, 32'd2);
    check("t2_addr_lo", {14'd0, a1}, 32'd0);
    check("t2_addr_hi", {14'd0, a2}, 32'd1);
    @(negedge clk);
    check("t2_idle_ready", {31'd0, bus5.ready}, 32'd1);
    check("t2_mem0", {16'd0, mem5[0]}, 32'h0000BEEF);
    check("t2_mem1", {16'd0, mem5[1]}, 32'h0000DEAD);
    check("t2_rdata", bus5.read_data, 32'd0);

    // Read back 1024
    @(posedge clk); #1 set_req(0, 1, 32'd1024, 32'd0);
    wait_done(lc, wc, a1, a2);
    check("t3_low", lc, 32'd5);
    check("t3_we", wc, 32'd0);
    check("t3_addr_lo", {14'd0, a1}, 32'd0);
    check("t3_addr_hi", {14'd0, a2}, 32'd1);
    check("t3_rdata", cur_rdata, 32'hDEADBEEF);
    set_req(0, 0, 32'd0, 32'd0);

    // Back-to-back write then read of 1028, no gap
    @(posedge clk); #1 set_req(1, 0, 32'd1028, 32'h12345678);
    wait_done(lc, wc, a1, a2);
    check("t4_wr_low", lc, 32'd5);
    check("t4_wr_we", wc, 32'd2);
    set_req(0, 1, 32'd1028, 32'd0);
    wait_done(lc, wc, a1, a2);
    check("t4_rd_low", lc, 32'd5);
    check("t4_rd_addr_lo", {14'd0, a1}, 32'd2);
    check("t4_rd_addr_hi", {14'd0, a2}, 32'd3);
    check("t4_rdata", cur_rdata, 32'h12345678);
    set_req(0, 0, 32'd0, 32'd0);
    idle_low = 0;
    repeat (4) begin
      @(negedge clk);
      if (!bus5.ready || st5 != 3'd0) idle_low++;
    end
    check("t4_no_extra", idle_low, 32'd0);
    check("t4_mem2", {16'd0, mem5[2]}, 32'h00005678);
    check("t4_mem3", {16'd0, mem5[3]}, 32'h00001234);

    // Simultaneous rd_en and wr_en: write wins
    @(posedge clk); #1 set_req(1, 1, 32'd1032, 32'hA5A5A5A5);
    wait_done(lc, wc, a1, a2);
    set_req(0, 0, 32'd0, 32'd0);
    check("t5_low", lc, 32'd5);
    check("t5_we", wc, 32'd2);
    @(negedge clk);
    check("t5_mem4", {16'd0, mem5[4]}, 32'h0000A5A5);
    check("t5_mem5", {16'd0, mem5[5]}, 32'h0000A5A5);
    check("t5_rdata", bus5.read_data, 32'h12345678);

    // Three-cycle build: no wait states
    sel = 1'b1;
    @(posedge clk); #1 set_req(1, 0, 32'd1024, 32'hCAFEF00D);
    wait_done(lc, wc, a1, a2);
    set_req(0, 0, 32'd0, 32'd0);
    check("t6_wr_low", lc, 32'd3);
    check("t6_wr_we", wc, 32'd2);
    @(posedge clk); #1 set_req(0, 1, 32'd1024, 32'd0);
    wait_done(lc, wc, a1, a2);
    check("t6_rd_low", lc, 32'd3);
    check("t6_rdata", cur_rdata, 32'hCAFEF00D);
    set_req(0, 0, 32'd0, 32'd0);
    @(negedge clk);
    check("t6_mem0", {16'd0, mem3[0]}, 32'h0000F00D);
    check("t6_mem1", {16'd0, mem3[1]}, 32'h0000CAFE);
    check("t6_no_wait", {31'd0, saw_wait3}, 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
